// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
package ps2_kbd_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_LEN = 3'd7;

  // One decoded key event; rel marks a break (key release)
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_evt_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: falling-edge detect on the (already clk_sys-synchronous)
// PS/2 clock, 11-bit frame deserialiser and stalled-frame timeout.
module ps2_frame_rx
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       err_stb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e        state_r;
  rx_state_e        state_s;
  logic             clk_q_r;
  logic [7:0]       sr_r;
  logic [3:0]       bit_cnt_r;
  logic             par_r;
  logic             stop_r;
  logic [CNT_W-1:0] idle_cnt_r;
  logic             fall_s;
  logic             timeout_s;
  logic             frame_ok_s;

  assign fall_s     = clk_q_r & ~ps2_kbd_clk;
  assign timeout_s  = (state_r == SHIFT) & ~fall_s & (idle_cnt_r == TIMEOUT_LAST);
  assign frame_ok_s = odd_parity_ok(sr_r, par_r) & stop_r;
  assign rx_byte    = sr_r;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fall_s && !ps2_kbd_data) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (fall_s && (bit_cnt_r == 4'd9)) begin
          state_s = CHECK;
        end else if (timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      CHECK:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Strobe outputs: byte on a good frame, error on bad start/parity/stop or stall
  always_comb begin
    byte_stb = 1'b0;
    err_stb  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s && ps2_kbd_data) begin
          err_stb = 1'b1;
        end else begin
          err_stb = 1'b0;
        end
      end
      SHIFT: err_stb = timeout_s;
      CHECK: begin
        byte_stb = frame_ok_s;
        err_stb  = ~frame_ok_s;
      end
      default: begin
        byte_stb = 1'b0;
        err_stb  = 1'b0;
      end
    endcase
  end

  // Edge detector, shift register, bit counter and stall counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_q_r    <= 1'b0;
      sr_r       <= 8'h00;
      bit_cnt_r  <= 4'd0;
      par_r      <= 1'b0;
      stop_r     <= 1'b0;
      idle_cnt_r <= {CNT_W{1'b0}};
    end else begin
      clk_q_r <= ps2_kbd_clk;
      case (state_r)
        IDLE: begin
          bit_cnt_r  <= 4'd0;
          idle_cnt_r <= {CNT_W{1'b0}};
        end
        SHIFT: begin
          if (fall_s) begin
            idle_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
            case (bit_cnt_r)
              4'd8:    par_r  <= ps2_kbd_data;
              4'd9:    stop_r <= ps2_kbd_data;
              default: sr_r   <= {ps2_kbd_data, sr_r[7:1]};
            endcase
          end else if (timeout_s) begin
            bit_cnt_r  <= 4'd0;
            idle_cnt_r <= {CNT_W{1'b0}};
          end else begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          idle_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: frame receiver, E0/F0/E1 prefix folding and a
// valid/ready event output. Define PS2_KBD_FIFO_EN to replace the single
// output register by a FIFO_DEPTH-entry event FIFO.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
`ifdef PS2_KBD_FIFO_EN
  ,
  parameter int FIFO_DEPTH  = 4
`endif
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       overrun
);

  logic [7:0] rx_byte_s;
  logic       byte_stb_s;
  logic       err_stb_s;
  logic       ext_pend_r;
  logic       brk_pend_r;
  logic [2:0] pause_cnt_r;
  logic       emit_s;
  kbd_evt_t   evt_s;
  logic       frame_err_r;
  logic       overrun_r;

  ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .rx_byte      (rx_byte_s),
    .byte_stb     (byte_stb_s),
    .err_stb      (err_stb_s)
  );

  // Decide whether the received byte produces a key event
  always_comb begin
    emit_s = 1'b0;
    evt_s  = {1'b0, 1'b0, 8'h00};
    if (byte_stb_s) begin
      if (pause_cnt_r != 3'd0) begin
        if (pause_cnt_r == 3'd1) begin
          emit_s = 1'b1;
          evt_s  = {1'b0, 1'b0, PS2_PFX_PAUSE};
        end else begin
          emit_s = 1'b0;
        end
      end else if ((rx_byte_s == PS2_PFX_EXT) || (rx_byte_s == PS2_PFX_BRK) ||
                   (rx_byte_s == PS2_PFX_PAUSE)) begin
        emit_s = 1'b0;
      end else begin
        emit_s = 1'b1;
        evt_s  = {ext_pend_r, brk_pend_r, rx_byte_s};
      end
    end else begin
      emit_s = 1'b0;
    end
  end

  // Prefix flags and pause-sequence swallow counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      pause_cnt_r <= 3'd0;
    end else if (byte_stb_s) begin
      if (pause_cnt_r != 3'd0) begin
        pause_cnt_r <= pause_cnt_r - 3'd1;
      end else begin
        case (rx_byte_s)
          PS2_PFX_EXT:   ext_pend_r  <= 1'b1;
          PS2_PFX_BRK:   brk_pend_r  <= 1'b1;
          PS2_PFX_PAUSE: pause_cnt_r <= PS2_PAUSE_LEN;
          default: begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered frame error pulse, aligned with the event output stage
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= err_stb_s;
    end
  end

  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

`ifdef PS2_KBD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  kbd_evt_t       mem_r [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  logic           empty_s;
  logic           full_s;
  logic           pop_s;
  logic           push_s;
  kbd_evt_t       head_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_s   = ~empty_s & key_ready;
  assign push_s  = emit_s & (~full_s | pop_s);
  assign head_s  = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Event FIFO storage, pointers and sticky overrun
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_r  <= {(PTR_W+1){1'b0}};
      rd_ptr_r  <= {(PTR_W+1){1'b0}};
      overrun_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {1'b0, 1'b0, 8'h00};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= evt_s;
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (emit_s && full_s && !pop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign key_valid   = ~empty_s;
  assign key_code    = head_s.code;
  assign key_ext     = head_s.ext;
  assign key_release = head_s.rel;
`else
  kbd_evt_t evt_r;
  logic     key_valid_r;
  logic     accept_s;

  assign accept_s = key_valid_r & key_ready;

  // Single output register; a new event while one is pending and not accepted is dropped
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      evt_r       <= {1'b0, 1'b0, 8'h00};
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (emit_s) begin
      if (!key_valid_r || accept_s) begin
        evt_r       <= evt_s;
        key_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (accept_s) begin
      key_valid_r <= 1'b0;
    end
  end

  assign key_valid   = key_valid_r;
  assign key_code    = evt_r.code;
  assign key_ext     = evt_r.ext;
  assign key_release = evt_r.rel;
`endif

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: expected events are queued as
// frames are sent and compared as the DUT hands them over.
module tb_ps2_kbd_decoder;

  localparam int TO = 1000;
  localparam int H  = 4;
  localparam int FD = 4;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int valid_cycles = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_release  (key_release),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  // Scoreboard: compare each accepted event against the head of the expected queue
  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_seen++;
    if (key_valid === 1'b1) valid_cycles++;
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got ext=%b rel=%b code=%h", key_ext, key_release, key_code);
      end else begin
        mon_e = exp_q.pop_front();
        if ({key_ext, key_release, key_code} !== mon_e) begin
          bad++;
          $display("FAIL event got ext=%b rel=%b code=%h exp ext=%b rel=%b code=%h",
                   key_ext, key_release, key_code, mon_e[9], mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_kbd_data = f[i];
      ps2_kbd_clk  = 1'b1;
      cyc(H);
      ps2_kbd_clk  = 1'b0;
      cyc(H);
    end
    ps2_kbd_clk  = 1'b1;
    ps2_kbd_data = 1'b1;
    cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0, 1'b1), 11);
  endtask

  task automatic exp_push(input logic e, input logic r, input logic [7:0] c);
    exp_q.push_back({e, r, c});
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    total++;
    if ({key_valid, key_ext, key_release, key_code, frame_err, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b e=%b r=%b c=%h fe=%b ov=%b exp all 0",
               key_valid, key_ext, key_release, key_code, frame_err, overrun);
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_single();
    logic [10:0] f;
    int vc0;
    key_ready = 1'b1;
    vc0 = valid_cycles;
    f = mk_frame(8'h1C, 1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 8'h1C);
    send_bits(f, 10);
    ps2_kbd_data = f[10];
    ps2_kbd_clk  = 1'b1;
    cyc(H);
    ps2_kbd_clk  = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got valid=%b exp=0", key_valid);
    end
    @(negedge clk_sys);
    total++;
    if (key_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_rise got valid=%b exp=1", key_valid);
    end
    cyc(H);
    ps2_kbd_clk  = 1'b1;
    ps2_kbd_data = 1'b1;
    cyc(10);
    total++;
    if (valid_cycles - vc0 !== 1) begin
      bad++;
      $display("FAIL valid_width got=%0d exp=1", valid_cycles - vc0);
    end
    check_drained("single_drain");
  endtask

  task automatic test_prefix();
    key_ready = 1'b1;
    exp_push(1'b1, 1'b1, 8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    exp_push(1'b0, 1'b1, 8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    exp_push(1'b1, 1'b0, 8'h4A);
    send_byte(8'hE0); send_byte(8'h4A);
    exp_push(1'b0, 1'b0, 8'hFA);
    send_byte(8'hFA);
    exp_push(1'b0, 1'b0, 8'hAA);
    send_byte(8'hAA);
    cyc(5);
    check_drained("prefix_drain");
  endtask

  task automatic test_frame_errors();
    int e0;
    logic [10:0] f;
    key_ready = 1'b1;
    e0 = err_seen;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL parity_err got=%0d exp=1", err_seen - e0);
    end
    exp_push(1'b0, 1'b0, 8'h32);
    send_byte(8'h32);
    e0 = err_seen;
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 11);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL stop_err got=%0d exp=1", err_seen - e0);
    end
    e0 = err_seen;
    f = 11'h7FF;
    send_bits(f, 1);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL start_err got=%0d exp=1", err_seen - e0);
    end
    // an E0 prefix survives a corrupted frame
    exp_push(1'b1, 1'b0, 8'h6B);
    send_byte(8'hE0);
    send_bits(mk_frame(8'h6B, 1'b1, 1'b1), 11);
    send_byte(8'h6B);
    cyc(5);
    check_drained("frame_err_drain");
  endtask

  task automatic test_timeout();
    int e0;
    key_ready = 1'b1;
    e0 = err_seen;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 4);
    cyc(TO + 10);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++;
      $display("FAIL timeout_err got=%0d exp=1", err_seen - e0);
    end
    exp_push(1'b0, 1'b0, 8'h29);
    send_byte(8'h29);
    cyc(5);
    check_drained("timeout_drain");
  endtask

  task automatic test_overrun();
    key_ready = 1'b0;
`ifdef PS2_KBD_FIFO_EN
    exp_push(1'b0, 1'b0, 8'h1C);
    exp_push(1'b0, 1'b0, 8'h32);
    send_byte(8'h1C);
    send_byte(8'h32);
    key_ready = 1'b1;
    cyc(6);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL fifo_no_overrun got=%b exp=0", overrun);
    end
    check_drained("fifo_two_drain");
    key_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < FD) exp_push(1'b0, 1'b0, 8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL fifo_overrun got=%b exp=1", overrun);
    end
    key_ready = 1'b1;
    cyc(10);
    check_drained("fifo_full_drain");
`else
    exp_push(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C);
    send_byte(8'h32);
    total++;
    if ({key_valid, key_code, overrun} !== {1'b1, 8'h1C, 1'b1}) begin
      bad++;
      $display("FAIL hold_overrun got v=%b c=%h ov=%b exp v=1 c=1c ov=1", key_valid, key_code, overrun);
    end
    key_ready = 1'b1;
    cyc(3);
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got valid=%b exp=0", key_valid);
    end
    check_drained("hold_drain");
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    logic pe, pb;
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c  = 8'($urandom_range(1, 127));
      pe = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      exp_push(pe, pb, c);
      if (pe) send_byte(8'hE0);
      if (pb) send_byte(8'hF0);
      send_byte(c);
    end
    cyc(5);
    check_drained("b2b_drain");
  endtask

  task automatic test_pause();
    key_ready = 1'b1;
    exp_push(1'b0, 1'b0, 8'hE1);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    cyc(5);
    check_drained("pause_drain");
    send_byte(8'hE1);
    send_byte(8'h14);
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 5);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    total++;
    if ({key_valid, overrun} !== 2'b00) begin
      bad++;
      $display("FAIL pause_reset got v=%b ov=%b exp v=0 ov=0", key_valid, overrun);
    end
    exp_push(1'b0, 1'b0, 8'h1C);
    send_byte(8'h1C);
    cyc(5);
    check_drained("post_reset_drain");
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_frame_errors();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_pause();
    cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
